// File: rtl/double_buffer_ctrl.sv
// double_buffer_ctrl: ping-pong frame buffer controller over a dual-port RAM.
// A writer fills one bank (wr_bank) while a reader reads the other (~wr_bank).
// Banks exchange once a frame is complete and the reader has released its bank.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   wr_valid/wr_data/wr_last     writer word stream; wr_ready accepts it
//   rd_req/rd_addr               reader word request (index within read bank)
//   rd_data/rd_valid             read word, valid one cycle after rd_req
//   rd_frame_done                reader has finished with its bank (pulse)
//   swap                         one-cycle pulse when banks exchange
//   rd_bank_valid                read bank holds a completed frame
//   ram_*                        dual-port RAM: port A write, port B read
//   rd_word_count                words in the frame just swapped in
//                                (present only with DBUF_WORD_COUNT_EN defined)
module double_buffer_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-2:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_frame_done,
  output logic              swap,
  output logic              rd_bank_valid,
`ifdef DBUF_WORD_COUNT_EN
  output logic [ADDR_W-1:0] rd_word_count,
`endif
  output logic [ADDR_W-1:0] ram_ada,
  output logic [ADDR_W-1:0] ram_adb,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_cea,
  output logic              ram_ceb,
  output logic              ram_oce,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] PTR_MAX = '1;

  typedef enum logic {ST_FILL, ST_WAIT} state_t;

  state_t            state, state_next;
  logic              wr_bank;
  logic [PTR_W-1:0]  wr_ptr;
  logic              done_pend;
  logic              done_next;
  logic              swap_next;
  logic              accept;

  assign accept    = wr_valid && (state == ST_FILL);
  // A release arriving in the swap cycle is dropped: the swap clears the flag.
  assign done_next = swap ? 1'b0 : (done_pend | rd_frame_done);
  // swap is registered one cycle ahead so it is high exactly while in WAIT
  // with a pending release, i.e. in the cycle before the banks toggle.
  assign swap_next = (state_next == ST_WAIT) && done_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FILL;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if (accept && (wr_last || (wr_ptr == PTR_MAX))) state_next = ST_WAIT;
      ST_WAIT: if (done_pend) state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  // Output decode and RAM port drive
  always_comb begin
    wr_ready = (state == ST_FILL);
    ram_cea  = 1'b0;
    ram_ceb  = 1'b0;
    ram_ada  = {wr_bank, wr_ptr};
    ram_adb  = {~wr_bank, rd_addr};
    ram_din  = wr_data;
    if (!reset) begin
      ram_cea = accept;
      ram_ceb = rd_req;
    end
  end

  assign ram_oce = 1'b1;
  assign rd_data = ram_dout;

  // Bank, pointer, release flag and read-valid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank       <= 1'b0;
      wr_ptr        <= '0;
      done_pend     <= 1'b1;
      rd_bank_valid <= 1'b0;
      swap          <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid  <= rd_req;
      done_pend <= done_next;
      swap      <= swap_next;
      if (swap) begin
        wr_bank       <= ~wr_bank;
        wr_ptr        <= '0;
        rd_bank_valid <= 1'b1;
      end else if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

`ifdef DBUF_WORD_COUNT_EN
  // A full bank wraps the pointer to zero, which stands for 256 words.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_count <= '0;
    end else if (swap) begin
      if (wr_ptr == '0) rd_word_count <= {1'b1, {PTR_W{1'b0}}};
      else              rd_word_count <= {1'b0, wr_ptr};
    end
  end
`endif

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// Testbench for double_buffer_ctrl: frame table plus reset/release corner cases,
// with a behavioural dual-port RAM and a read-data scoreboard.
module tb_double_buffer_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-2:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_frame_done;
  logic              swap;
  logic              rd_bank_valid;
  logic [ADDR_W-1:0] rd_word_count;
  logic [ADDR_W-1:0] ram_ada, ram_adb;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic              ram_cea, ram_ceb, ram_oce;

  always #5 clk = ~clk;

  double_buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_frame_done(rd_frame_done), .swap(swap), .rd_bank_valid(rd_bank_valid),
`ifdef DBUF_WORD_COUNT_EN
    .rd_word_count(rd_word_count),
`endif
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_din(ram_din),
    .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_oce(ram_oce), .ram_dout(ram_dout)
  );

  // Behavioural RAM: registered read, one cycle latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_cea) mem[ram_ada] <= ram_din;
    if (ram_ceb) ram_dout <= mem[ram_adb];
  end

  int tests = 0;
  int fails = 0;
  int swap_cnt = 0;
  logic exp_bank;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int          len;
    logic        last;
    logic [31:0] base;
    int          idx;
    logic        hold;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every valid read word must match the oldest expected word
  always @(negedge clk) begin
    if (swap === 1'b1) swap_cnt++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 expected no read pending");
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_frame(input int len, input logic [31:0] base,
                             input logic last, input logic done_on_last);
    for (int k = 0; k < len; k++) begin
      wr_valid      = 1'b1;
      wr_data       = base + 32'(k);
      wr_last       = last && (k == len - 1);
      rd_frame_done = done_on_last && (k == len - 1);
      #1;
      chk("wr_ready_fill", 32'(wr_ready), 32'd1);
      chk("ram_cea_wr", 32'(ram_cea), 32'd1);
      chk("ram_ada", 32'(ram_ada), 32'({exp_bank, 8'(k)}));
      chk("ram_din", ram_din, base + 32'(k));
      cycle();
    end
    wr_valid      = 1'b0;
    wr_last       = 1'b0;
    rd_frame_done = 1'b0;
  endtask

  // Drive one read request and record the word the reader should get back
  task automatic issue(input int idx, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_addr = 8'(idx);
    exp_q.push_back(exp);
    #1;
    chk("ram_ceb", 32'(ram_ceb), 32'd1);
    chk("ram_adb", 32'(ram_adb), 32'({~exp_bank, 8'(idx)}));
  endtask

  task automatic read_word(input int idx, input logic [31:0] exp);
    issue(idx, exp);
    cycle();
    rd_req = 1'b0;
    chk("rd_valid_lat", 32'(rd_valid), 32'd1);
    cycle();
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
  endtask

  int s0;

  initial begin
    tbl[0] = '{len: 4,   last: 1'b1, base: 32'hA0,   idx: 2,   hold: 1'b0};
    tbl[1] = '{len: 256, last: 1'b0, base: 32'h100,  idx: 255, hold: 1'b1};
    tbl[2] = '{len: 7,   last: 1'b1, base: 32'h2000, idx: 6,   hold: 1'b0};

    reset = 1'b1; wr_valid = 1'b1; wr_data = '0; wr_last = 1'b0;
    rd_req = 1'b1; rd_addr = '0; rd_frame_done = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_cea", 32'(ram_cea), 32'd0);
    chk("reset_ceb", 32'(ram_ceb), 32'd0);
    cycle();
    reset = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    exp_bank = 1'b0;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("ram_oce", 32'(ram_oce), 32'd1);
`ifdef DBUF_WORD_COUNT_EN
    chk("rst_word_count", 32'(rd_word_count), 32'd0);
`endif
    #1;
    chk("idle_cea", 32'(ram_cea), 32'd0);
    cycle();
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);

    // Frame table: write, wait for release, swap, read back
    for (int i = 0; i < 3; i++) begin
      write_frame(tbl[i].len, tbl[i].base, tbl[i].last, 1'b0);
      if (i > 0) begin
        for (int w = 0; w < 3; w++) begin
          chk("wait_wr_ready", 32'(wr_ready), 32'd0);
          chk("wait_no_swap", 32'(swap), 32'd0);
          cycle();
        end
        rd_frame_done = 1'b1;
        cycle();
      end
      rd_frame_done = (i > 0) && tbl[i].hold;
      chk("swap_pulse", 32'(swap), 32'd1);
      chk("swap_wr_ready", 32'(wr_ready), 32'd0);
      if (i > 0) issue(tbl[i-1].idx, tbl[i-1].base + 32'(tbl[i-1].idx));
      cycle();
      rd_req = 1'b0;
      rd_frame_done = 1'b0;
      exp_bank = ~exp_bank;
      chk("swap_end", 32'(swap), 32'd0);
      chk("rd_bank_valid", 32'(rd_bank_valid), 32'd1);
      chk("post_swap_wr_ready", 32'(wr_ready), 32'd1);
`ifdef DBUF_WORD_COUNT_EN
      chk("rd_word_count", 32'(rd_word_count), 32'(tbl[i].len));
`endif
      read_word(tbl[i].idx, tbl[i].base + 32'(tbl[i].idx));
    end

    // Release in the same cycle as the last word: exactly one swap
    s0 = swap_cnt;
    write_frame(3, 32'h3000, 1'b1, 1'b1);
    chk("coinc_swap", 32'(swap), 32'd1);
    cycle();
    exp_bank = ~exp_bank;
    chk("coinc_swap_end", 32'(swap), 32'd0);
    cycle();
    cycle();
    chk("coinc_swap_count", 32'(swap_cnt - s0), 32'd1);
    read_word(1, 32'h3001);

    // Reset in mid-frame abandons the partial frame
    write_frame(10, 32'h4000, 1'b0, 1'b0);
    s0 = swap_cnt;
    reset = 1'b1; wr_valid = 1'b1; rd_req = 1'b1;
    #1;
    chk("midrst_cea", 32'(ram_cea), 32'd0);
    chk("midrst_ceb", 32'(ram_ceb), 32'd0);
    cycle();
    reset = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    exp_bank = 1'b0;
    chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("midrst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    chk("midrst_swap", 32'(swap), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_swap_count", 32'(swap_cnt - s0), 32'd0);
    write_frame(2, 32'h5000, 1'b1, 1'b0);
    chk("postrst_swap", 32'(swap), 32'd1);
    cycle();
    exp_bank = 1'b1;
    chk("postrst_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
`ifdef DBUF_WORD_COUNT_EN
    chk("postrst_word_count", 32'(rd_word_count), 32'd2);
`endif
    read_word(0, 32'h5000);
    cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/double_buffer_ctrl.md
DOUBLE_BUFFER_CTRL -- requirements
Module: double_buffer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the word width of the write, read and RAM data paths.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the RAM address width; the MSB selects the bank and the lower ADDR_W-1 bits give the word index, so each bank holds 256 words.
REQ-003 clk  in  1  single clock for all logic; it also clocks both RAM ports.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_valid  in  1  writer presents a word.
REQ-006 wr_data  in  DATA_W  write word.
REQ-007 wr_last  in  1  qualifies the final word of a frame.
REQ-008 wr_ready  out  1  controller accepts a word; a transfer occurs when wr_valid and wr_ready are both 1.
REQ-009 rd_req  in  1  reader requests one word.
REQ-010 rd_addr  in  ADDR_W-1  word index within the read bank.
REQ-011 rd_data  out  DATA_W  read word, driven straight from ram_dout.
REQ-012 rd_valid  out  1  rd_data is valid this cycle.
REQ-013 rd_frame_done  in  1  one-cycle pulse: reader has finished with the current read bank.
REQ-014 swap  out  1  one-cycle pulse: banks exchanged.
REQ-015 rd_bank_valid  out  1  read bank holds a completed frame.
REQ-016 ram_ada, ram_adb  out  ADDR_W each  RAM write and read addresses; ram_din out DATA_W; ram_cea, ram_ceb out 1 each; ram_oce out 1, tied 1; ram_dout in DATA_W.

Function
REQ-017 SHALL keep a wr_bank bit; the read bank SHALL always be ~wr_bank.
REQ-018 SHALL run write FSM states FILL and WAIT; in FILL, wr_ready=1; in WAIT, wr_ready=0.
REQ-019 On an accepted word SHALL set ram_cea=1, ram_ada={wr_bank,wr_ptr} and ram_din=wr_data, combinationally in the same cycle, then increment the 8-bit wr_ptr.
REQ-020 SHALL go FILL->WAIT when the accepted word has wr_last=1 or when wr_ptr==255; the pointer SHALL NOT wrap into a new frame.
REQ-021 SHALL set the sticky flag done_pend on rd_frame_done and clear it on swap; rd_frame_done arriving in the swap cycle SHALL be discarded.
REQ-022 In WAIT with done_pend=1, SHALL on the next clock toggle wr_bank, clear wr_ptr, clear done_pend, set rd_bank_valid=1, pulse swap for one cycle and return to FILL.
REQ-023 Read path: SHALL set ram_ceb=rd_req and ram_adb={~wr_bank,rd_addr}; rd_valid SHALL be rd_req delayed by one cycle, giving 1-cycle latency.
REQ-024 A read issued in the swap cycle SHALL use the pre-swap bank.
REQ-025 rd_req SHALL be honoured even when rd_bank_valid=0; the data is then undefined.
REQ-026 When wr_valid=0 in FILL, SHALL set ram_cea=0 and hold the FSM state.

Reset
REQ-027 On reset SHALL set state=FILL, wr_bank=0, wr_ptr=0, done_pend=1, rd_bank_valid=0, swap=0 and rd_valid=0; this lets the first completed frame swap immediately.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame without swapping.
REQ-029 ram_cea and ram_ceb SHALL be 0 in any cycle where reset=1.

Configuration
REQ-030 With DBUF_WORD_COUNT_EN defined, SHALL add output rd_word_count[ADDR_W-1:0], latched at swap to the number of words written in the completed frame (1..256), reset 0.
REQ-031 Without DBUF_WORD_COUNT_EN, SHALL omit the rd_word_count port and its register; all other behaviour is identical.

Verification
REQ-032 After reset, write 4 words 0xA0..0xA3 with wr_last on 0xA3 -> swap pulses 1 cycle after the last word; rd_bank_valid=1; reading index 2 returns 0xA2 with rd_valid one cycle later.
REQ-033 Write 256 words with no wr_last -> WAIT entered after word 255; wr_ready=0 until rd_frame_done; rd_word_count=256 (macro on).
REQ-034 Complete frame 2 without rd_frame_done -> wr_ready stays 0 and no swap; pulse rd_frame_done -> swap on the next cycle; the read bank now returns frame 2 data.
REQ-035 Assert rd_frame_done in the same cycle frame 3's last word is accepted -> exactly one swap, on the following cycle.
REQ-036 Assert reset after 10 words of a frame -> no swap; rd_bank_valid=0; wr_bank=0; wr_ready=1 on the first cycle after reset.
